ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Three-way arbiter (video, loader, CPU) in front of a single-port synchronous RAM.
// Each access takes IDLE->SETUP->READ->ACK, with a CPU starvation override on video priority.
module ram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk_in,
  input  logic          RESET,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_dout,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_dout,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_din,
  output logic          ld_ack,
  input  logic          ld_active,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  // Counter must be able to hold STARVE_MAX itself, and be at least one bit wide.
  localparam int CW = $clog2(STARVE_MAX + 2);

  typedef enum logic [1:0] {IDLE, SETUP, READ, ACK} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_VID, SRC_LD, SRC_CPU} src_t;

  state_t        state_r;
  src_t          owner_r;
  src_t          pick_s;
  logic          we_r;
  logic [CW-1:0] starve_r;
  logic          cpu_elig_s;
  logic          starved_s;

  // Winner selection from the requests present in the current cycle.
  always_comb begin
    cpu_elig_s = cpu_req & ~ld_active;
    starved_s  = cpu_elig_s && (starve_r >= CW'(STARVE_MAX));
    pick_s     = SRC_NONE;
    if (starved_s) begin
      pick_s = SRC_CPU;
    end else if (vid_req) begin
      pick_s = SRC_VID;
    end else if (ld_req) begin
      pick_s = SRC_LD;
    end else if (cpu_elig_s) begin
      pick_s = SRC_CPU;
    end else begin
      pick_s = SRC_NONE;
    end
  end

  // Access sequencer: latches the winner, drives the RAM, returns data and acks.
  always_ff @(posedge clk_in) begin
    if (RESET) begin
      state_r  <= IDLE;
      owner_r  <= SRC_NONE;
      we_r     <= 1'b0;
      starve_r <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      busy     <= 1'b0;
      vid_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      ld_ack   <= 1'b0;
      vid_dout <= '0;
      cpu_dout <= '0;
    end else begin
      ram_we  <= 1'b0;
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      ld_ack  <= 1'b0;

      // Starvation bookkeeping only counts video wins that actually held off an eligible CPU.
      if (!cpu_req) begin
        starve_r <= '0;
      end else if (state_r == IDLE && pick_s == SRC_CPU) begin
        starve_r <= '0;
      end else if (state_r == IDLE && pick_s == SRC_VID && cpu_elig_s &&
                   starve_r < CW'(STARVE_MAX)) begin
        starve_r <= starve_r + CW'(1);
      end else begin
        starve_r <= starve_r;
      end

      case (state_r)
        IDLE: begin
          if (pick_s != SRC_NONE) begin
            state_r <= SETUP;
            busy    <= 1'b1;
            owner_r <= pick_s;
            case (pick_s)
              SRC_VID: begin
                ram_addr <= vid_addr;
                we_r     <= 1'b0;
              end
              SRC_LD: begin
                ram_addr <= ld_addr;
                ram_din  <= ld_din;
                ram_we   <= 1'b1;
                we_r     <= 1'b1;
              end
              SRC_CPU: begin
                ram_addr <= cpu_addr;
                ram_din  <= cpu_din;
                ram_we   <= cpu_we;
                we_r     <= cpu_we;
              end
              default: we_r <= 1'b0;
            endcase
          end
        end
        SETUP: state_r <= READ;
        READ: begin
          state_r <= ACK;
          case (owner_r)
            SRC_VID: begin
              vid_ack  <= 1'b1;
              vid_dout <= ram_dout;
            end
            SRC_LD:  ld_ack <= 1'b1;
            SRC_CPU: begin
              cpu_ack <= 1'b1;
              if (!we_r) cpu_dout <= ram_dout;
            end
            default: ;
          endcase
        end
        ACK: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural sync RAM plus hand-computed expectations.
module tb_ram_arbiter;

  logic        clk_in = 1'b0;
  logic        RESET;
  logic        vid_req, cpu_req, cpu_we, ld_req, ld_active;
  logic [15:0] vid_addr, cpu_addr, ld_addr;
  logic [7:0]  cpu_din, ld_din;
  logic        vid_ack, cpu_ack, ld_ack, ram_we, busy;
  logic [7:0]  vid_dout, cpu_dout, ram_din, ram_dout;
  logic [15:0] ram_addr;
  logic [7:0]  mem [0:65535];

  int total = 0;
  int bad   = 0;

  ram_arbiter dut (
    .clk_in(clk_in), .RESET(RESET),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
    .ld_active(ld_active),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // Single-port RAM with one cycle of read latency.
  always @(posedge clk_in) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5;
    RESET = 1'b1; vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; ld_req = 1'b0;
    ld_active = 1'b0; vid_addr = 16'h0000; cpu_addr = 16'h0000; ld_addr = 16'h0000;
    cpu_din = 8'h00; ld_din = 8'h00;
    tick(); tick();
    check("rst_outs", {vid_ack, cpu_ack, ld_ack, ram_we, busy}, 32'h0);
    check("rst_data", {ram_addr, ram_din, vid_dout, cpu_dout}, 32'h0);
    RESET = 1'b0;
    tick();

    // CPU read of 0x1234
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    tick();
    check("rd_addr", {ram_addr, ram_we, busy}, {16'h1234, 1'b0, 1'b1});
    tick();
    check("rd_n2_ack", cpu_ack, 32'h0);
    tick();
    check("rd_ack", {cpu_ack, cpu_dout}, {1'b1, 8'hA5});
    cpu_req = 1'b0;
    tick();
    check("rd_n4", {cpu_ack, busy}, 32'h0);

    // CPU write 0x41 to 0xBB80
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hBB80; cpu_din = 8'h41;
    tick();
    check("wr_setup", {ram_we, ram_addr, ram_din}, {1'b1, 16'hBB80, 8'h41});
    tick();
    check("wr_we_off", ram_we, 32'h0);
    tick();
    check("wr_ack", {cpu_ack, cpu_dout, ram_we}, {1'b1, 8'hA5, 1'b0});
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    check("wr_mem", mem[16'hBB80], 32'h41);

    // Video read back of 0xBB80
    vid_req = 1'b1; vid_addr = 16'hBB80;
    tick(); tick(); tick();
    check("vid_ack", {vid_ack, vid_dout, cpu_ack}, {1'b1, 8'h41, 1'b0});
    vid_req = 1'b0;
    tick();

    // Loader write while download active blocks CPU read of same address
    ld_active = 1'b1; ld_req = 1'b1; ld_addr = 16'h0500; ld_din = 8'h3C;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0500;
    tick();
    check("ld_setup", {ram_we, ram_addr, ram_din}, {1'b1, 16'h0500, 8'h3C});
    tick(); tick();
    check("ld_ack", {ld_ack, cpu_ack}, {1'b1, 1'b0});
    ld_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("ld_blk", {cpu_ack, busy}, 32'h0);
    end
    ld_active = 1'b0;
    tick(); tick();
    check("blk_n2", cpu_ack, 32'h0);
    tick();
    check("blk_ack", {cpu_ack, cpu_dout}, {1'b1, 8'h3C});
    cpu_req = 1'b0;
    tick();

    // Contention: expect V,V,V,C repeating, loader starved out
    vid_req = 1'b1; vid_addr = 16'hBB80;
    ld_req = 1'b1; ld_addr = 16'h0600; ld_din = 8'h77;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    for (int g = 0; g < 8; g++) begin
      for (int k = 1; k <= 4; k++) begin
        tick();
        if (k == 3)
          check($sformatf("cont_g%0d", g), {vid_ack, ld_ack, cpu_ack},
                (g % 4 == 3) ? 32'b001 : 32'b100);
        else
          check($sformatf("cont_g%0d_k%0d", g, k), {vid_ack, ld_ack, cpu_ack}, 32'b000);
      end
    end
    check("cont_douts", {vid_dout, cpu_dout}, {8'h41, 8'hA5});
    vid_req = 1'b0; ld_req = 1'b0; cpu_req = 1'b0;
    tick(); tick();

    // Reset during SETUP of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0777; cpu_din = 8'h99;
    tick();
    check("mr_setup", ram_we, 32'h1);
    RESET = 1'b1;
    tick();
    check("mr_outs", {vid_ack, cpu_ack, ld_ack, ram_we, busy}, 32'h0);
    check("mr_data", {ram_addr, ram_din, vid_dout, cpu_dout}, 32'h0);
    RESET = 1'b0;
    tick();
    check("mr_r1", {ram_we, ram_addr, cpu_ack}, {1'b1, 16'h0777, 1'b0});
    tick();
    check("mr_r2", cpu_ack, 32'h0);
    tick();
    check("mr_r3", cpu_ack, 32'h1);
    cpu_req = 1'b0;
    tick();
    check("mr_r4", {cpu_ack, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
